// File: rtl/spc_write_arbiter_if.sv
// Handshake and write-port bundle for spc_write_arbiter.
// zr_violation exists only when SPC_ARB_ZR_PROTECT_EN is defined.
interface spc_write_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_lock;
   logic [3*NREQ-1:0]  req_addr;
   logic [32*NREQ-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               wr_usr_enable;
   logic [2:0]         write_usr_addr;
   logic [31:0]        usr_data;
   logic               lock_active;
   logic [2:0]         lock_owner;
   logic               lock_timeout;
`ifdef SPC_ARB_ZR_PROTECT_EN
   logic               zr_violation;
`endif

   modport master (
      output req_valid,
      output req_lock,
      output req_addr,
      output req_data,
      input  req_ready,
      input  wr_usr_enable,
      input  write_usr_addr,
      input  usr_data,
      input  lock_active,
      input  lock_owner,
`ifdef SPC_ARB_ZR_PROTECT_EN
      input  zr_violation,
`endif
      input  lock_timeout
   );

   modport slave (
      input  req_valid,
      input  req_lock,
      input  req_addr,
      input  req_data,
      output req_ready,
      output wr_usr_enable,
      output write_usr_addr,
      output usr_data,
      output lock_active,
      output lock_owner,
`ifdef SPC_ARB_ZR_PROTECT_EN
      output zr_violation,
`endif
      output lock_timeout
   );
endinterface

// File: rtl/spc_write_arbiter.sv
// Round-robin arbiter with lock/timeout for the special-register write port.
// Optional ZR write suppression: define SPC_ARB_ZR_PROTECT_EN.
module spc_write_arbiter #(
   parameter int NREQ     = 3,
   parameter int LOCK_MAX = 15
) (
   input  logic clk,
   input  logic reset,
   spc_write_arbiter_if.slave bus
);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   localparam logic [7:0] CNT_LIM = 8'(LOCK_MAX - 1);

   state_t      r_state;
   logic [2:0]  r_rr_ptr;
   logic [2:0]  r_owner;
   logic [7:0]  r_cnt;
   logic        r_wen;
   logic [2:0]  r_addr;
   logic [31:0] r_data;
   logic        r_timeout;
`ifdef SPC_ARB_ZR_PROTECT_EN
   logic        r_zr;
`endif

   logic [NREQ-1:0] w_grant;
   logic            w_xfer;
   int              w_idx;
   logic [2:0]      w_addr;
   logic [31:0]     w_data;
   logic            w_lock;
   logic [2:0]      w_next_ptr;
   logic [2:0]      w_owner_next;

   function automatic int f_wrap(input int v);
      return (v >= NREQ) ? v - NREQ : v;
   endfunction

   // rr_ptr never exceeds NREQ-1, so one subtraction covers any NREQ.
   always_comb begin
      w_grant = '0;
      w_idx   = 0;
      w_xfer  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (r_state == S_LOCKED) begin
            if (!w_xfer && k == int'(r_owner) && bus.req_valid[k]) begin
               w_grant[k] = 1'b1;
               w_idx      = k;
               w_xfer     = 1'b1;
            end
         end else if (!w_xfer &&
                      bus.req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
            w_idx          = f_wrap(int'(r_rr_ptr) + k);
            w_grant[w_idx] = 1'b1;
            w_xfer         = 1'b1;
         end
      end
   end

   assign w_addr       = bus.req_addr[3*w_idx +: 3];
   assign w_data       = bus.req_data[32*w_idx +: 32];
   assign w_lock       = bus.req_lock[w_idx];
   assign w_next_ptr   = (w_idx == NREQ - 1) ? 3'd0 : 3'(w_idx + 1);
   assign w_owner_next = (int'(r_owner) == NREQ - 1) ? 3'd0
                                                     : r_owner + 3'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_owner   <= '0;
         r_cnt     <= '0;
         r_wen     <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_timeout <= 1'b0;
`ifdef SPC_ARB_ZR_PROTECT_EN
         r_zr      <= 1'b0;
`endif
      end else begin
         r_wen     <= 1'b0;
         r_timeout <= 1'b0;
         if (w_xfer) begin
`ifdef SPC_ARB_ZR_PROTECT_EN
            if (w_addr == 3'd0) begin
               r_zr <= 1'b1;
            end else begin
               r_wen  <= 1'b1;
               r_addr <= w_addr;
               r_data <= w_data;
            end
`else
            r_wen  <= 1'b1;
            r_addr <= w_addr;
            r_data <= w_data;
`endif
         end
         unique case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_rr_ptr <= w_next_ptr;
                  if (w_lock) begin
                     r_state <= S_LOCKED;
                     r_owner <= 3'(w_idx);
                     r_cnt   <= '0;
                  end
               end
            end
            S_LOCKED: begin
               // An owner write wins over an expiring counter.
               if (w_xfer) begin
                  r_cnt <= '0;
                  if (!w_lock) begin
                     r_state  <= S_IDLE;
                     r_rr_ptr <= w_next_ptr;
                  end
               end else if (r_cnt == CNT_LIM) begin
                  r_state   <= S_IDLE;
                  r_cnt     <= '0;
                  r_timeout <= 1'b1;
                  r_rr_ptr  <= w_owner_next;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
         endcase
      end
   end

   assign bus.req_ready      = w_grant;
   assign bus.wr_usr_enable  = r_wen;
   assign bus.write_usr_addr = r_addr;
   assign bus.usr_data       = r_data;
   assign bus.lock_active    = (r_state == S_LOCKED);
   assign bus.lock_owner     = r_owner;
   assign bus.lock_timeout   = r_timeout;
`ifdef SPC_ARB_ZR_PROTECT_EN
   assign bus.zr_violation   = r_zr;
`endif

endmodule

// File: tb/tb_spc_write_arbiter.sv
// Directed bench for spc_write_arbiter (NREQ=3, LOCK_MAX=15).
// Inputs change at posedge+1; ready sampled at negedge, registers at posedge+1.
module tb_spc_write_arbiter;

   localparam int NREQ = 3;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   spc_write_arbiter_if #(.NREQ(NREQ)) bus ();

   spc_write_arbiter #(
      .NREQ     (NREQ),
      .LOCK_MAX (15)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic lk,
                          input logic [2:0] a, input logic [31:0] d);
      bus.req_valid[i]        = v;
      bus.req_lock[i]         = lk;
      bus.req_addr[3*i +: 3]  = a;
      bus.req_data[32*i +: 32] = d;
   endtask

   task automatic clr_all();
      bus.req_valid = '0;
      bus.req_lock  = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      bus.req_valid = '0;
      bus.req_lock  = '0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      #3;
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
           bus.lock_active, bus.lock_owner, bus.lock_timeout} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b %h %h %b %h %b want all 0",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
                  bus.lock_active, bus.lock_owner, bus.lock_timeout);
      end
      n_cmp++;
      if (bus.req_ready !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ready: got %b want 000", bus.req_ready);
      end
`ifdef SPC_ARB_ZR_PROTECT_EN
      n_cmp++;
      if (bus.zr_violation !== 1'b0) begin
         n_err++;
         $display("FAIL reset_zr: got %b want 0", bus.zr_violation);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_req(0, 1'b1, 1'b0, 3'd4, 32'h0000_1000);
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
         n_err++;
         $display("FAIL single_ready: got %b want 001", bus.req_ready);
      end
      tick();
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data} !==
          {1'b1, 3'd4, 32'h0000_1000}) begin
         n_err++;
         $display("FAIL single_write: got %b %h %h want 1 4 00001000",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data);
      end
      clr_all();
      tick();
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data} !==
          {1'b0, 3'd4, 32'h0000_1000}) begin
         n_err++;
         $display("FAIL single_hold: got %b %h %h want 0 4 00001000",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data);
      end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_rdy;
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 1'b1, 1'b0, 3'(i + 1), 32'hA0 + 32'(i));
      for (int k = 0; k < 6; k++) begin
         exp_rdy = 3'b001 << (k % 3);
         #4;
         n_cmp++;
         if (bus.req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL rr_ready[%0d]: got %b want %b",
                     k, bus.req_ready, exp_rdy);
         end
         tick();
         n_cmp++;
         if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data} !==
             {1'b1, 3'((k % 3) + 1), 32'hA0 + 32'(k % 3)}) begin
            n_err++;
            $display("FAIL rr_write[%0d]: got %b %h %h want 1 %0d %h",
                     k, bus.wr_usr_enable, bus.write_usr_addr,
                     bus.usr_data, (k % 3) + 1, 32'hA0 + 32'(k % 3));
         end
      end
      clr_all();
      tick();
      n_cmp++;
      if (bus.wr_usr_enable !== 1'b0) begin
         n_err++;
         $display("FAIL rr_idle: got %b want 0", bus.wr_usr_enable);
      end
   endtask

   task automatic test_lock();
      logic [2:0] seq_a [3];
      logic       seq_l [3];
      seq_a = '{3'd5, 3'd6, 3'd7};
      seq_l = '{1'b1, 1'b1, 1'b0};
      set_req(0, 1'b0, 1'b0, 3'd1, 32'h11);
      set_req(1, 1'b0, 1'b0, 3'd2, 32'h22);
      for (int k = 0; k < 3; k++) begin
         set_req(2, 1'b1, seq_l[k], seq_a[k], 32'h50 + 32'(k));
         #4;
         n_cmp++;
         if (bus.req_ready !== 3'b100) begin
            n_err++;
            $display("FAIL lock_ready[%0d]: got %b want 100",
                     k, bus.req_ready);
         end
         tick();
         n_cmp++;
         if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
              bus.lock_active} !==
             {1'b1, seq_a[k], 32'h50 + 32'(k), (k < 2)}) begin
            n_err++;
            $display("FAIL lock_write[%0d]: got %b %h %h act=%b",
                     k, bus.wr_usr_enable, bus.write_usr_addr,
                     bus.usr_data, bus.lock_active);
         end
         if (k == 0) begin
            n_cmp++;
            if (bus.lock_owner !== 3'd2) begin
               n_err++;
               $display("FAIL lock_owner: got %0d want 2", bus.lock_owner);
            end
            bus.req_valid[0] = 1'b1;
            bus.req_valid[1] = 1'b1;
         end
      end
      bus.req_valid[2] = 1'b0;
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
         n_err++;
         $display("FAIL lock_after: got %b want 001", bus.req_ready);
      end
      tick();
      clr_all();
      tick();
   endtask

   task automatic test_timeout();
      set_req(1, 1'b1, 1'b1, 3'd3, 32'h33);
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b010) begin
         n_err++;
         $display("FAIL to_grant: got %b want 010", bus.req_ready);
      end
      tick();
      clr_all();
      set_req(0, 1'b1, 1'b0, 3'd2, 32'h22);
      for (int n = 1; n <= 15; n++) begin
         #4;
         n_cmp++;
         if ({bus.req_ready, bus.lock_active, bus.lock_timeout} !==
             {3'b000, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL to_hold[%0d]: rdy=%b act=%b to=%b want 000 1 0",
                     n, bus.req_ready, bus.lock_active, bus.lock_timeout);
         end
         tick();
      end
      n_cmp++;
      if ({bus.lock_timeout, bus.lock_active, bus.wr_usr_enable} !==
          3'b100) begin
         n_err++;
         $display("FAIL to_pulse: to=%b act=%b wen=%b want 1 0 0",
                  bus.lock_timeout, bus.lock_active, bus.wr_usr_enable);
      end
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
         n_err++;
         $display("FAIL to_next: got %b want 001", bus.req_ready);
      end
      tick();
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
           bus.lock_timeout} !== {1'b1, 3'd2, 32'h22, 1'b0}) begin
         n_err++;
         $display("FAIL to_write: got %b %h %h to=%b want 1 2 22 0",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
                  bus.lock_timeout);
      end
      clr_all();
      tick();
   endtask

   task automatic test_simultaneous();
      set_req(1, 1'b1, 1'b1, 3'd3, 32'h33);
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b010) begin
         n_err++;
         $display("FAIL sim_grant: got %b want 010", bus.req_ready);
      end
      tick();
      clr_all();
      for (int n = 0; n < 14; n++) tick();
      set_req(1, 1'b1, 1'b1, 3'd6, 32'h66);
      tick();
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
           bus.lock_active, bus.lock_timeout} !==
          {1'b1, 3'd6, 32'h66, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL sim_edge: got %b %h %h act=%b to=%b want 1 6 66 1 0",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
                  bus.lock_active, bus.lock_timeout);
      end
      set_req(1, 1'b1, 1'b0, 3'd7, 32'h77);
      tick();
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
           bus.lock_active, bus.lock_timeout} !==
          {1'b1, 3'd7, 32'h77, 1'b0, 1'b0}) begin
         n_err++;
         $display("FAIL sim_release: got %b %h %h act=%b to=%b want 1 7 77 0 0",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data,
                  bus.lock_active, bus.lock_timeout);
      end
      clr_all();
      tick();
   endtask

   task automatic test_reset_mid_lock();
      set_req(1, 1'b1, 1'b1, 3'd5, 32'h5A5A);
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b010) begin
         n_err++;
         $display("FAIL rml_grant: got %b want 010", bus.req_ready);
      end
      tick();
      n_cmp++;
      if ({bus.wr_usr_enable, bus.lock_active, bus.lock_owner} !==
          {1'b1, 1'b1, 3'd1}) begin
         n_err++;
         $display("FAIL rml_locked: wen=%b act=%b own=%0d want 1 1 1",
                  bus.wr_usr_enable, bus.lock_active, bus.lock_owner);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.wr_usr_enable, bus.lock_active, bus.lock_owner,
           bus.lock_timeout} !== '0) begin
         n_err++;
         $display("FAIL rml_async: wen=%b act=%b own=%0d to=%b want 0",
                  bus.wr_usr_enable, bus.lock_active, bus.lock_owner,
                  bus.lock_timeout);
      end
      clr_all();
      @(negedge clk);
      reset = 1'b1;
      tick();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 1'b1, 1'b0, 3'(i + 1), 32'hC0 + 32'(i));
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
         n_err++;
         $display("FAIL rml_ptr: got %b want 001", bus.req_ready);
      end
      tick();
      clr_all();
      tick();
   endtask

   task automatic test_zr();
      set_req(0, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF);
      #4;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
         n_err++;
         $display("FAIL zr_ready: got %b want 001", bus.req_ready);
      end
      tick();
      clr_all();
`ifdef SPC_ARB_ZR_PROTECT_EN
      n_cmp++;
      if ({bus.wr_usr_enable, bus.zr_violation} !== 2'b01) begin
         n_err++;
         $display("FAIL zr_block: wen=%b zr=%b want 0 1",
                  bus.wr_usr_enable, bus.zr_violation);
      end
      tick();
      tick();
      n_cmp++;
      if (bus.zr_violation !== 1'b1) begin
         n_err++;
         $display("FAIL zr_sticky: got %b want 1", bus.zr_violation);
      end
`else
      n_cmp++;
      if ({bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data} !==
          {1'b1, 3'd0, 32'hDEAD_BEEF}) begin
         n_err++;
         $display("FAIL zr_pass: got %b %h %h want 1 0 deadbeef",
                  bus.wr_usr_enable, bus.write_usr_addr, bus.usr_data);
      end
      tick();
`endif
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_timeout();
      test_simultaneous();
      test_reset_mid_lock();
      test_zr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spc_write_arbiter.md
Name: spc_write_arbiter

Overview:
- Shares the single user write port of the special register file (ZR, R1–R3, SP, LR, PC, CPSR) among NREQ requesters: decode/execute, load/store and exception unit.
- Arbitration is round-robin, with one registered write per cycle.
- A requester may lock the port so that multi-write sequences stay atomic, for example exception entry writing LR, PC and CPSR.
- A lock timeout guards against an owner that never releases.

Parameters:
- NREQ, 3: number of requesters, 2..8.
- LOCK_MAX, 15: idle cycles the lock owner may hold the port before a forced release, 1..255.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  asynchronous, active-low reset; asserting low clears all state immediately.
- req_valid  in  NREQ  per-requester write request.
- req_lock  in  NREQ  hold-grant request, sampled with an accepted write.
- req_addr  in  3*NREQ  target special register; requester i occupies bits [3i+2:3i].
- req_data  in  32*NREQ  write data; requester i occupies bits [32i+31:32i].
- req_ready  out  NREQ  one-hot accept for the current cycle (combinational).
- wr_usr_enable  out  1  registered write strobe to the register file.
- write_usr_addr  out  3  registered write address.
- usr_data  out  32  registered write data.
- lock_active  out  1  the port is locked.
- lock_owner  out  3  index of the current lock owner.
- lock_timeout  out  1  one-cycle pulse on a forced lock release.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer rr_ptr = 0;
  - timeout counter 0.
- Transfer rule: a transfer occurs on cycle t when req_valid[i] && req_ready[i].
  - On cycle t+1: wr_usr_enable=1, write_usr_addr=req_addr[i], usr_data=req_data[i].
  - Otherwise wr_usr_enable=0; addr and data hold their last values.
  - Latency is 1 cycle; throughput is 1 write per cycle.
- At most one req_ready bit is high. req_ready never depends on req_lock.
- Requesters must hold valid, addr and data stable until accepted. The arbiter has no buffering beyond the output register.
- State IDLE:
  - Grant goes to the first valid requester scanning from rr_ptr upward, with wrap.
  - On a transfer from i: rr_ptr = (i+1) mod NREQ.
  - If req_lock[i]=1 on the transfer: go to LOCKED, lock_owner=i, counter=0.
- State LOCKED:
  - Only lock_owner can receive ready; all other requesters stall.
  - Owner transfer with req_lock=1: stay LOCKED, counter=0.
  - Owner transfer with req_lock=0: write is performed, go to IDLE, rr_ptr = owner+1.
  - Cycle without an owner transfer: counter+1.
  - When the counter reaches LOCK_MAX: go to IDLE; lock_timeout pulses next cycle; rr_ptr = owner+1. No write is generated.
- lock_active=1 exactly while in LOCKED, and is registered.
- Wrap: rr_ptr wraps from NREQ-1 to 0. The scan must handle a non-power-of-2 NREQ.
- Simultaneous events: the owner transfer and the counter reaching LOCK_MAX in the same cycle resolve as a transfer. The counter resets and there is no timeout.
- Reset mid-operation: a pending output write is dropped (wr_usr_enable forced to 0) and any lock is released immediately.
- Address 0 (ZR) is forwarded unchanged unless the Optional Feature is enabled.

Optional Feature:
- Macro: SPC_ARB_ZR_PROTECT_EN.
- Defined:
  - A transfer with req_addr=0 is accepted (ready asserted, lock semantics honoured) but produces wr_usr_enable=0 on cycle t+1.
  - Output sticky flag zr_violation (1 bit, reset 0) is set on such a transfer and clears only on reset.
- Undefined: the zr_violation port is absent and ZR writes pass through like any other address.

Test Plan:
- Single request: reset released; req0 valid, addr=4, data=0x0000_1000 → req_ready=001 same cycle; next cycle wr_usr_enable=1, addr=4, data=0x1000.
- Round-robin: all three valid continuously for 6 cycles, addrs 1/2/3 → grants 0,1,2,0,1,2; writes appear 1 cycle after each grant.
- Lock sequence:
  - req2 locks with three writes (addr 5, 6, 7; req_lock=1,1,0) while req0 and req1 stay valid;
  - required: req0 and req1 are stalled throughout, lock_active=1 for those cycles, then req0 is granted next.
- Lock timeout: req1 locks, then drops valid for LOCK_MAX=15 cycles while req0 waits → lock_timeout pulse, lock_active falls, req0 is granted on the following cycle.
- Reset mid-lock: reset asserted low asynchronously during LOCKED with a write in the output register → wr_usr_enable, lock_active and lock_owner go to 0 immediately; after release the arbiter is in IDLE with rr_ptr=0.
- ZR protect (macro defined): req0 writes addr=0, data=0xDEAD_BEEF → ready=1, no wr_usr_enable, zr_violation=1 and sticky.
